// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with a FIFO of (pc, instruction) pairs toward decode.
module inst_fetch #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]    state;
    logic          stale;
    logic [TW-1:0] tmr;
    logic [31:0]   req_pc;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          accept, aligned, done, push, pop;

    // rst gates pc_ready so every output reads 0 while reset is held
    assign pc_ready   = rst && state == IDLE && count < (AW+1)'(DEPTH) && !redirect;
    assign accept     = pc_valid && pc_ready;
    assign aligned    = pc_in[1:0] == 2'b00;
    assign done       = state == WAIT && (imem_rvalid || tmr == TW'(TIMEOUT - 1));
    assign push       = state == WAIT && imem_rvalid && !stale && !redirect;
    assign inst_valid = count != '0;
    assign pop        = inst_valid && inst_ready;
    assign inst_out   = inst_valid ? mem[rd_ptr][31:0] : '0;
    assign inst_pc    = inst_valid ? mem[rd_ptr][63:32] : '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {req_pc, imem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stale     <= 1'b0;
            tmr       <= '0;
            req_pc    <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            fetch_err <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            imem_req <= accept && aligned;
            if (accept) begin
                if (aligned) begin
                    imem_addr <= pc_in;
                    req_pc    <= pc_in;
                    state     <= WAIT;
                    tmr       <= '0;
                    stale     <= 1'b0;
                end else begin
                    fetch_err <= 1'b1;
                end
            end else if (state == WAIT) begin
                if (done) begin
                    state <= IDLE;
                    stale <= 1'b0;
                    if (!imem_rvalid && !stale) fetch_err <= 1'b1;
                end else begin
                    tmr <= tmr + 1'b1;
                    // the request stays outstanding; its response must not land in the buffer
                    if (redirect) stale <= 1'b1;
                end
            end
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus random traffic checked every cycle against a queue-based model.
module tb_inst_fetch;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0, redirect = 1'b0, inst_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        pc_ready, imem_req, inst_valid, fetch_err;
    logic [31:0] imem_addr, inst_out, inst_pc;

    inst_fetch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .redirect(redirect), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outstanding-request flag, stale flag, wait-cycle count and a queue of {pc, word}
    bit          m_busy, m_stale, m_req, m_err;
    int          m_wcnt;
    logic [31:0] m_addr, m_rpc;
    logic [63:0] q[$];
    logic [31:0] popped[$];

    task automatic model_step();
        bit r, acc;
        r   = redirect;
        acc = pc_valid && !m_busy && q.size() < DEPTH && !r;
        m_req = 0;
        if (q.size() > 0 && inst_ready) void'(q.pop_front());
        if (m_busy) begin
            m_wcnt++;
            if (imem_rvalid) begin
                if (!m_stale && !r) q.push_back({m_rpc, imem_rdata});
                m_busy = 0; m_stale = 0;
            end else if (m_wcnt == TIMEOUT) begin
                if (!m_stale) m_err = 1;
                m_busy = 0; m_stale = 0;
            end else if (r) m_stale = 1;
        end
        if (r) q.delete();
        if (acc) begin
            if (pc_in[1:0] != 2'b00) m_err = 1;
            else begin
                m_req = 1; m_addr = pc_in; m_rpc = pc_in; m_busy = 1; m_wcnt = 0; m_stale = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 0; m_stale = 0; m_req = 0; m_err = 0; m_wcnt = 0;
            m_addr = '0; m_rpc = '0; q.delete();
        end else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("pc_ready", 32'(pc_ready), 32'(!m_busy && q.size() < DEPTH && !redirect));
            chk("imem_req", 32'(imem_req), 32'(m_req));
            chk("imem_addr", imem_addr, m_addr);
            chk("inst_valid", 32'(inst_valid), 32'(q.size() > 0));
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
            if (q.size() > 0) begin
                chk("inst_pc", inst_pc, q[0][63:32]);
                chk("inst_out", inst_out, q[0][31:0]);
                chk("inst_word_of_pc", inst_out, inst_pc ^ 32'h13);
            end
            if (inst_valid && inst_ready) popped.push_back(inst_pc);
        end
    end

    // Memory: answers each request after lat cycles with addr^0x13; lat==0 never answers
    int lat = 1, due = 0;
    logic [31:0] raddr = '0;
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            due = 0; imem_rvalid = 0;
        end else begin
            #1;
            imem_rvalid = 0;
            if (due > 0) begin
                due--;
                if (due == 0) begin imem_rvalid = 1; imem_rdata = raddr ^ 32'h13; end
            end
            if (imem_req && lat > 0) begin due = lat; raddr = imem_addr; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] pc);
        pc_valid = 1; pc_in = pc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pc_ready) begin tick(); pc_valid = 0; return; end
        end
        n_chk++; n_fail++;
        $display("FAIL send %h: pc_ready never rose", pc);
        tick(); pc_valid = 0;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (inst_valid) return;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: inst_valid never rose", nm);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pc_ready"}, 32'(pc_ready), 0);
        chk({nm, "_imem_req"}, 32'(imem_req), 0);
        chk({nm, "_imem_addr"}, imem_addr, 0);
        chk({nm, "_inst_valid"}, 32'(inst_valid), 0);
        chk({nm, "_inst_out"}, inst_out, 0);
        chk({nm, "_inst_pc"}, inst_pc, 0);
        chk({nm, "_fetch_err"}, 32'(fetch_err), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1;
        inst_ready = 1;
        send(32'h0);
        @(negedge clk);
        chk("t1_req", 32'(imem_req), 1);
        chk("t1_addr", imem_addr, 0);
        @(negedge clk);
        chk("t1_valid_n2", 32'(inst_valid), 0);
        @(negedge clk);
        chk("t1_valid_n3", 32'(inst_valid), 1);
        chk("t1_pc", inst_pc, 0);
        chk("t1_inst", inst_out, 32'h13);
        tick();
        popped.delete();
        for (int i = 0; i < 4; i++) send(32'(4 * i));
        repeat (8) tick();
        chk("t2_count", 32'(popped.size()), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("t2_order", popped[i], 32'(4 * i));

        inst_ready = 0;
        popped.delete();
        send(32'h0);
        send(32'h4);
        pc_valid = 1; pc_in = 32'h8;
        repeat (6) @(negedge clk);
        chk("t3_stall", 32'(pc_ready), 0);
        chk("t3_full_valid", 32'(inst_valid), 1);
        chk("t3_head", inst_pc, 0);
        tick();
        inst_ready = 1;
        send(32'h8);
        repeat (8) tick();
        chk("t3_count", 32'(popped.size()), 3);
        for (int i = 0; i < 3 && i < popped.size(); i++) chk("t3_order", popped[i], 32'(4 * i));

        lat = 5;
        send(32'd32);
        tick();
        redirect = 1;
        tick();
        redirect = 0;
        repeat (8) tick();
        @(negedge clk);
        chk("t4_dropped", 32'(inst_valid), 0);
        tick();
        lat = 1;
        send(32'd40);
        wait_valid("t4");
        chk("t4_pc", inst_pc, 32'd40);
        chk("t4_err", 32'(fetch_err), 0);
        tick();

        lat = 0;
        send(32'd100);
        repeat (16) @(negedge clk);
        chk("t5_err_early", 32'(fetch_err), 0);
        @(negedge clk);
        chk("t5_err", 32'(fetch_err), 1);
        chk("t5_ready", 32'(pc_ready), 1);
        lat = 1;
        tick();
        send(32'd44);
        wait_valid("t5");
        chk("t5_pc", inst_pc, 32'd44);
        chk("t5_err_sticky", 32'(fetch_err), 1);
        tick();

        rst = 0;
        tick();
        rst = 1;
        send(32'h42);
        @(negedge clk);
        chk("t6_no_req", 32'(imem_req), 0);
        chk("t6_err", 32'(fetch_err), 1);
        repeat (3) @(negedge clk);
        chk("t6_no_inst", 32'(inst_valid), 0);
        tick();
        lat = 0;
        send(32'h8);
        #2 rst = 0;
        #1 chk_zero("async_reset");
        tick(); tick();
        rst = 1;
        lat = 1;

        for (int c = 0; c < 3000; c++) begin
            tick();
            pc_valid   = $urandom_range(0, 3) != 0;
            pc_in      = ($urandom_range(0, 31) == 0) ? $urandom : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            redirect   = $urandom_range(0, 11) == 0;
            inst_ready = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 9))
                0:       lat = 20;
                1, 2:    lat = 5;
                3, 4:    lat = 2;
                5:       lat = 3;
                default: lat = 1;
            endcase
        end
        tick();
        pc_valid = 0; redirect = 0; inst_ready = 1; lat = 1;
        repeat (30) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
